// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared definitions for the multicycle MIPS controller.
// Holds the FSM state encoding, opcode and Funct constants, the ALUOp
// encodings and the ALUControl encodings, plus an opcode-legality helper.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Funct field (IR[5:0]) for R-type
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALUControl encodings
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: controller <-> Datapath signal bundle.
//   master : controller side (receives Op/Funct, drives controls/status)
//   slave  : Datapath side (drives Op/Funct, receives controls/status)
interface multicycle_controller_if;

    logic [5:0] Op;
    logic [5:0] Funct;
    logic       IorD;
    logic       IRWrite;
    logic       RegDest;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       Branch;
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic       MemWrite;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  Op, Funct,
        output IorD, IRWrite, RegDest, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
               ALUControl, Branch, PCWrite, PCSrc, MemWrite, IllegalOp, State
    );

    modport slave (
        output Op, Funct,
        input  IorD, IRWrite, RegDest, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
               ALUControl, Branch, PCWrite, PCSrc, MemWrite, IllegalOp, State
    );

endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: combinational ALUControl decode.
//   ALUOp[1:0]      : operation class from the controller FSM
//   Funct[5:0]      : R-type function field
//   ALUControl[2:0] : ALU operation select
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] Funct,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALUCTL_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALUCTL_ADD;
            ALUOP_SUB: ALUControl = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (Funct)
                    FUNCT_ADD: ALUControl = ALUCTL_ADD;
                    FUNCT_SUB: ALUControl = ALUCTL_SUB;
                    FUNCT_AND: ALUControl = ALUCTL_AND;
                    FUNCT_OR:  ALUControl = ALUCTL_OR;
                    FUNCT_SLT: ALUControl = ALUCTL_SLT;
                    default:   ALUControl = ALUCTL_ADD;
                endcase
            end
            // Unused ALUOp=11 falls back to add so the output is never X.
            default:   ALUControl = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM controller for a multicycle MIPS datapath.
//   ck, reset_        : clock (rising edge) and async active-low reset
//   Op, Funct         : IR[31:26] and IR[5:0] from the Datapath
//   IorD..PCSrc       : Datapath control outputs, decoded from state only
//   MemWrite          : data memory write strobe
//   IllegalOp         : sticky flag, set leaving DECODE on an unsupported Op
//   State             : current FSM state for debug
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       ck,
    input  logic       reset_,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegDest,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       Branch,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       MemWrite,
    output logic       IllegalOp,
    output logic [3:0] State
);

    state_t state_q;
    state_t state_d;
    aluop_t alu_op;
    logic   illegal_q;

    always_ff @(posedge ck or negedge reset_) begin
        if (!reset_) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE && !op_supported(Op))
                illegal_q <= 1'b1;
        end
    end

    // Op is only consulted in DECODE and MEMADR; it is stable after FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (Op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD: state_d = MEMWB;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Moore outputs: depend on state_q only.
    always_comb begin
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        RegDest  = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        alu_op   = ALUOP_ADD;
        Branch   = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 2'b00;
        MemWrite = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            DECODE:   ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMREAD:  IorD = 1'b1;
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            ALUWB: begin
                RegDest  = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                Branch  = 1'b1;
                PCSrc   = 2'b01;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB:   RegWrite = 1'b1;
            JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (alu_op),
        .Funct      (Funct),
        .ALUControl (ALUControl)
    );

    assign IllegalOp = illegal_q;
    assign State     = state_q;

endmodule
